// File: rtl/demux32_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : demux32_stream_if
// Description : Stream bundle for the 1-to-2 word dispatcher. Carries the
//               upstream valid/ready/data/sel stream and the two downstream
//               valid/ready/data channels (A and B).
// Revision    : 1.0 - initial release
// ============================================================================
interface demux32_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_sel;

    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;

    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_data;

    // Environment side: produces the upstream stream, consumes both channels
    modport master (
        output in_valid, in_data, in_sel, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data
    );

    // Dispatcher side: consumes the upstream stream, produces both channels
    modport slave (
        input  in_valid, in_data, in_sel, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data
    );
endinterface
`default_nettype wire

// File: rtl/demux32_stream.sv
`default_nettype none
// ============================================================================
// Module      : demux32_stream
// Description : 1-to-2 stream dispatcher for 32-bit words. Each accepted word
//               is steered by in_sel into channel A (0) or channel B (1), each
//               channel buffering words in its own DEPTH-entry FIFO. Order is
//               preserved per channel; no same-cycle bypass.
//               Optional macro DEMUX32_STREAM_CNT_EN adds 16-bit wrapping
//               per-channel pop counters on ports cnt_a / cnt_b.
// Revision    : 1.0 - initial release
// ============================================================================
module demux32_stream #(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    demux32_stream_if.slave bus
`ifdef DEMUX32_STREAM_CNT_EN
    ,
    output logic [15:0]    cnt_a,
    output logic [15:0]    cnt_b
`endif
);

    localparam logic [AW:0]   c_full_count = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_count_one  = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one    = AW'(1);

    // Per-channel handshake terms, index 0 = channel A, index 1 = channel B
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_full;
    logic [1:0]       w_valid;
    logic [1:0]       w_out_ready;
    logic [1:0][31:0] w_head_data;
    logic             w_in_ready;
`ifdef DEMUX32_STREAM_CNT_EN
    logic [1:0][15:0] w_pops;
`endif

    assign w_out_ready = {bus.b_ready, bus.a_ready};

    // Upstream ready looks only at the selected channel's registered fill
    // level, so a pop in the same cycle cannot open the slot early and the
    // downstream readies never reach in_ready combinationally.
    assign w_in_ready   = rst_n & (bus.in_sel ? ~w_full[1] : ~w_full[0]);
    assign bus.in_ready = w_in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            localparam logic c_sel = 1'(gi);

            logic [AW-1:0] r_head;
            logic [AW-1:0] r_tail;
            logic [AW:0]   r_count;
            logic [31:0]   r_mem [DEPTH];

            assign w_full[gi]  = (r_count == c_full_count);
            assign w_valid[gi] = (r_count != '0);
            assign w_push[gi]  = bus.in_valid & w_in_ready & (bus.in_sel == c_sel);
            // An empty channel ignores its ready, so no underflow is possible
            assign w_pop[gi]   = w_valid[gi] & w_out_ready[gi];

            // Head word comes from storage only; forced to zero while empty so
            // the output is clean from reset onward.
            assign w_head_data[gi] = w_valid[gi] ? r_mem[r_head] : 32'h0;

            // Pointer and fill-level tracking; reset discards buffered words
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_head  <= '0;
                    r_tail  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push[gi]) begin
                        r_tail <= r_tail + c_ptr_one;
                    end
                    if (w_pop[gi]) begin
                        r_head <= r_head + c_ptr_one;
                    end
                    case ({w_push[gi], w_pop[gi]})
                        2'b10:   r_count <= r_count + c_count_one;
                        2'b01:   r_count <= r_count - c_count_one;
                        default: r_count <= r_count;
                    endcase
                end
            end

            // Storage write at the tail; contents are only visible through a
            // valid count, so the array needs no reset.
            always_ff @(posedge clk) begin
                if (w_push[gi]) begin
                    r_mem[r_tail] <= bus.in_data;
                end
            end

`ifdef DEMUX32_STREAM_CNT_EN
            logic [15:0] r_pops;

            // Free-running pop counter, wraps naturally at 16 bits
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pops <= 16'h0000;
                end else if (w_pop[gi]) begin
                    r_pops <= r_pops + 16'h0001;
                end
            end

            assign w_pops[gi] = r_pops;
`endif
        end
    endgenerate

    assign bus.a_valid = w_valid[0];
    assign bus.a_data  = w_head_data[0];
    assign bus.b_valid = w_valid[1];
    assign bus.b_data  = w_head_data[1];

`ifdef DEMUX32_STREAM_CNT_EN
    assign cnt_a = w_pops[0];
    assign cnt_b = w_pops[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux32_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux32_stream
// Description : Directed self-checking bench for demux32_stream. Inputs are
//               driven 1 ns after the rising edge, outputs checked before the
//               next rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux32_stream;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;

    demux32_stream_if bus ();

`ifdef DEMUX32_STREAM_CNT_EN
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
`endif

    demux32_stream #(
        .DEPTH (2),
        .AW    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef DEMUX32_STREAM_CNT_EN
        ,
        .cnt_a (cnt_a),
        .cnt_b (cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'h0;
        bus.in_sel   = 1'b0;
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        repeat (3) step();
        tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        tests++; if (bus.a_valid !== 1'b0) begin failed++; $display("FAIL reset_a_valid got=%b exp=0", bus.a_valid); end
        tests++; if (bus.b_valid !== 1'b0) begin failed++; $display("FAIL reset_b_valid got=%b exp=0", bus.b_valid); end
        tests++; if (bus.a_data !== 32'h0) begin failed++; $display("FAIL reset_a_data got=%h exp=0", bus.a_data); end
        tests++; if (bus.b_data !== 32'h0) begin failed++; $display("FAIL reset_b_data got=%h exp=0", bus.b_data); end
        rst_n = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL release_in_ready got=%b exp=1", bus.in_ready); end
        step();
    endtask

    task automatic test_routing();
        bus.a_ready  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        bus.in_data  = 32'h0000_00A1;
        #1;
        tests++; if (bus.a_valid !== 1'b0) begin failed++; $display("FAIL route_no_bypass got=%b exp=0", bus.a_valid); end
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.a_valid !== 1'b1) begin failed++; $display("FAIL route_a_valid got=%b exp=1", bus.a_valid); end
        tests++; if (bus.a_data !== 32'h0000_00A1) begin failed++; $display("FAIL route_a_data got=%h exp=000000a1", bus.a_data); end
        tests++; if (bus.b_valid !== 1'b0) begin failed++; $display("FAIL route_b_valid got=%b exp=0", bus.b_valid); end
        step();
        tests++; if (bus.a_valid !== 1'b0) begin failed++; $display("FAIL route_a_drained got=%b exp=0", bus.a_valid); end
        bus.a_ready = 1'b0;
    endtask

    task automatic test_fill_b();
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b1;
        bus.in_data  = 32'h11;
        step();
        bus.in_data  = 32'h22;
        step();
        bus.in_data  = 32'h33;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL fillb_ready_sel1 got=%b exp=0", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL fillb_ready_sel0 got=%b exp=1", bus.in_ready); end
        tests++; if (bus.b_data !== 32'h11) begin failed++; $display("FAIL fillb_hold_data got=%h exp=11", bus.b_data); end
        bus.b_ready = 1'b1;
        step();
        tests++; if (bus.b_valid !== 1'b1 || bus.b_data !== 32'h22) begin failed++; $display("FAIL fillb_second got=%b/%h exp=1/22", bus.b_valid, bus.b_data); end
        step();
        tests++; if (bus.b_valid !== 1'b0) begin failed++; $display("FAIL fillb_empty got=%b exp=0", bus.b_valid); end
        bus.b_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        bus.b_ready  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b1;
        bus.in_data  = 32'h11;
        step();
        bus.in_data  = 32'h22;
        step();
        bus.b_ready  = 1'b1;
        bus.in_data  = 32'h33;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin failed++; $display("FAIL fullpop_blocked got=%b exp=0", bus.in_ready); end
        tests++; if (bus.b_data !== 32'h11) begin failed++; $display("FAIL fullpop_head0 got=%h exp=11", bus.b_data); end
        step();
        tests++; if (bus.in_ready !== 1'b1) begin failed++; $display("FAIL fullpop_open got=%b exp=1", bus.in_ready); end
        tests++; if (bus.b_data !== 32'h22) begin failed++; $display("FAIL fullpop_head1 got=%h exp=22", bus.b_data); end
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.b_valid !== 1'b1 || bus.b_data !== 32'h33) begin failed++; $display("FAIL fullpop_head2 got=%b/%h exp=1/33", bus.b_valid, bus.b_data); end
        step();
        tests++; if (bus.b_valid !== 1'b0) begin failed++; $display("FAIL fullpop_empty got=%b exp=0", bus.b_valid); end
        bus.b_ready = 1'b0;
    endtask

    task automatic test_interleave();
        logic [31:0] words [4];
        logic        sels  [4];
        words[0] = 32'h100; sels[0] = 1'b0;
        words[1] = 32'h200; sels[1] = 1'b1;
        words[2] = 32'h101; sels[2] = 1'b0;
        words[3] = 32'h201; sels[3] = 1'b1;
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sel   = sels[i];
            bus.in_data  = words[i];
            step();
            if (sels[i] == 1'b0) begin
                tests++; if (bus.a_valid !== 1'b1 || bus.a_data !== words[i] || bus.b_valid !== 1'b0) begin
                    failed++; $display("FAIL interleave_%0d got=a%b/%h b%b exp=a1/%h b0", i, bus.a_valid, bus.a_data, bus.b_valid, words[i]);
                end
            end else begin
                tests++; if (bus.b_valid !== 1'b1 || bus.b_data !== words[i] || bus.a_valid !== 1'b0) begin
                    failed++; $display("FAIL interleave_%0d got=b%b/%h a%b exp=b1/%h a0", i, bus.b_valid, bus.b_data, bus.a_valid, words[i]);
                end
            end
        end
        bus.in_valid = 1'b0;
        step();
        tests++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin failed++; $display("FAIL interleave_drain got=%b%b exp=00", bus.a_valid, bus.b_valid); end
    endtask

    task automatic test_reset_midstream();
        bus.a_ready  = 1'b0;
        bus.b_ready  = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        bus.in_data  = 32'h300;
        step();
        bus.in_data  = 32'h301;
        step();
        bus.in_sel   = 1'b1;
        bus.in_data  = 32'h400;
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b1) begin failed++; $display("FAIL midrst_loaded got=%b%b exp=11", bus.a_valid, bus.b_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin failed++; $display("FAIL midrst_async got=%b%b exp=00", bus.a_valid, bus.b_valid); end
        tests++; if (bus.a_data !== 32'h0 || bus.in_ready !== 1'b0) begin failed++; $display("FAIL midrst_data got=%h/%b exp=0/0", bus.a_data, bus.in_ready); end
        #2;
        rst_n = 1'b1;
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        step();
        step();
        tests++; if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0) begin failed++; $display("FAIL midrst_stale got=%b%b exp=00", bus.a_valid, bus.b_valid); end
    endtask

`ifdef DEMUX32_STREAM_CNT_EN
    task automatic test_counters();
        tests++; if (cnt_a !== 16'h0 || cnt_b !== 16'h0) begin failed++; $display("FAIL cnt_reset got=%h/%h exp=0/0", cnt_a, cnt_b); end
        bus.a_ready  = 1'b1;
        bus.b_ready  = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        bus.in_data  = 32'h500;
        repeat (3) step();
        bus.in_sel   = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        tests++; if (cnt_a !== 16'd3 || cnt_b !== 16'd1) begin failed++; $display("FAIL cnt_basic got=%0d/%0d exp=3/1", cnt_a, cnt_b); end
        bus.in_valid = 1'b1;
        bus.in_sel   = 1'b0;
        repeat (65532) step();
        bus.in_valid = 1'b0;
        step();
        tests++; if (cnt_a !== 16'hFFFF) begin failed++; $display("FAIL cnt_preload got=%h exp=ffff", cnt_a); end
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        tests++; if (cnt_a !== 16'h0000 || cnt_b !== 16'd1) begin failed++; $display("FAIL cnt_wrap got=%h/%h exp=0000/0001", cnt_a, cnt_b); end
    endtask
`endif

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_routing();
        test_fill_b();
        test_full_pop();
        test_interleave();
        test_reset_midstream();
`ifdef DEMUX32_STREAM_CNT_EN
        test_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
